// File: rtl/sync_timing_stat_if.sv
// Host-side bundle for the SyncPort trigger-to-fallback timing statistics block.
interface sync_timing_stat_if #(
  parameter int _RAM_WIDTH_TIMING = 32,
  parameter int _CNT_WIDTH        = 16
);
  logic                         io_trigIn;
  logic                         io_fbCatch;
  logic [_RAM_WIDTH_TIMING-1:0] io_timeoutCnt;
  logic                         io_clear;
  logic                         work_End;
  logic                         io_busy;
  logic                         io_valid;
  logic                         io_hasSample;
  logic [_RAM_WIDTH_TIMING-1:0] io_timingLast;
  logic [_RAM_WIDTH_TIMING-1:0] io_timing1st;
  logic [_RAM_WIDTH_TIMING-1:0] io_timingMax;
  logic [_RAM_WIDTH_TIMING-1:0] io_timingMin;
  logic [_CNT_WIDTH-1:0]        io_sampleCnt;
  logic [_CNT_WIDTH-1:0]        io_toCnt;

  modport master (
    output io_trigIn, io_fbCatch, io_timeoutCnt, io_clear, work_End,
    input  io_busy, io_valid, io_hasSample, io_timingLast, io_timing1st,
           io_timingMax, io_timingMin, io_sampleCnt, io_toCnt
  );

  modport slave (
    input  io_trigIn, io_fbCatch, io_timeoutCnt, io_clear, work_End,
    output io_busy, io_valid, io_hasSample, io_timingLast, io_timing1st,
           io_timingMax, io_timingMin, io_sampleCnt, io_toCnt
  );
endinterface

// File: rtl/sync_timing_stat.sv
// Measures io_clk cycles from a SyncPort delayOut rising edge to the next fbCatch rising edge
// and keeps first/last/min/max latency, sample count and timeout count for the host.
module sync_timing_stat #(
  parameter int _RAM_WIDTH_TIMING = 32,
  parameter int _CNT_WIDTH        = 16
) (
  input logic               io_clk,
  input logic               io_rst_n,
  sync_timing_stat_if.slave bus
);
  localparam int TW = _RAM_WIDTH_TIMING;
  localparam int CW = _CNT_WIDTH;
  localparam logic [TW-1:0] LAT_ONE = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_e;

  function automatic logic [TW-1:0] sat_inc_lat(input logic [TW-1:0] v);
    logic [TW-1:0] r;
    if (v == {TW{1'b1}}) begin
      r = v;
    end else begin
      r = v + LAT_ONE;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == {CW{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [TW-1:0]   lat_cnt_q, lat_cnt_d;
  logic            trig_dly_q, trig_dly_d;
  logic            catch_dly_q, catch_dly_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            has_sample_q, has_sample_d;
  logic [TW-1:0]   t_last_q, t_last_d;
  logic [TW-1:0]   t_first_q, t_first_d;
  logic [TW-1:0]   t_max_q, t_max_d;
  logic [TW-1:0]   t_min_q, t_min_d;
  logic [CW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;

  logic            trig_rise_s;
  logic            catch_rise_s;
  logic            timeout_hit_s;
  logic            store_s;

  // Edge detection and timeout compare against the current count.
  always_comb begin
    trig_dly_d    = bus.io_trigIn;
    catch_dly_d   = bus.io_fbCatch;
    trig_rise_s   = bus.io_trigIn & ~trig_dly_q;
    catch_rise_s  = bus.io_fbCatch & ~catch_dly_q;
    timeout_hit_s = (bus.io_timeoutCnt != {TW{1'b0}}) && (lat_cnt_q == bus.io_timeoutCnt);
  end

  // Measurement FSM: catch beats timeout, timeout beats counting; clear overrides all.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    to_cnt_d  = to_cnt_q;
    store_s   = 1'b0;
    if (bus.io_clear) begin
      state_d   = ST_IDLE;
      lat_cnt_d = {TW{1'b0}};
      busy_d    = 1'b0;
      to_cnt_d  = {CW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig_rise_s && !bus.work_End) begin
            state_d   = ST_MEAS;
            lat_cnt_d = LAT_ONE;
            busy_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MEAS: begin
          if (catch_rise_s) begin
            store_s = 1'b1;
            valid_d = 1'b1;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (timeout_hit_s) begin
            to_cnt_d = sat_inc_cnt(to_cnt_q);
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
          end else begin
            lat_cnt_d = sat_inc_lat(lat_cnt_q);
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Statistics update on a stored latency; the first sample seeds first/min/max.
  always_comb begin
    has_sample_d = has_sample_q;
    t_last_d     = t_last_q;
    t_first_d    = t_first_q;
    t_max_d      = t_max_q;
    t_min_d      = t_min_q;
    sample_cnt_d = sample_cnt_q;
    if (bus.io_clear) begin
      has_sample_d = 1'b0;
      t_last_d     = {TW{1'b0}};
      t_first_d    = {TW{1'b0}};
      t_max_d      = {TW{1'b0}};
      t_min_d      = {TW{1'b0}};
      sample_cnt_d = {CW{1'b0}};
    end else if (store_s) begin
      t_last_d     = lat_cnt_q;
      sample_cnt_d = sat_inc_cnt(sample_cnt_q);
      if (!has_sample_q) begin
        has_sample_d = 1'b1;
        t_first_d    = lat_cnt_q;
        t_max_d      = lat_cnt_q;
        t_min_d      = lat_cnt_q;
      end else begin
        if (lat_cnt_q > t_max_q) begin
          t_max_d = lat_cnt_q;
        end else begin
          t_max_d = t_max_q;
        end
        if (lat_cnt_q < t_min_q) begin
          t_min_d = lat_cnt_q;
        end else begin
          t_min_d = t_min_q;
        end
      end
    end else begin
      has_sample_d = has_sample_q;
    end
  end

  // State and statistics registers.
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= {TW{1'b0}};
      trig_dly_q   <= 1'b0;
      catch_dly_q  <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      has_sample_q <= 1'b0;
      t_last_q     <= {TW{1'b0}};
      t_first_q    <= {TW{1'b0}};
      t_max_q      <= {TW{1'b0}};
      t_min_q      <= {TW{1'b0}};
      sample_cnt_q <= {CW{1'b0}};
      to_cnt_q     <= {CW{1'b0}};
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      trig_dly_q   <= trig_dly_d;
      catch_dly_q  <= catch_dly_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      has_sample_q <= has_sample_d;
      t_last_q     <= t_last_d;
      t_first_q    <= t_first_d;
      t_max_q      <= t_max_d;
      t_min_q      <= t_min_d;
      sample_cnt_q <= sample_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign bus.io_busy       = busy_q;
  assign bus.io_valid      = valid_q;
  assign bus.io_hasSample  = has_sample_q;
  assign bus.io_timingLast = t_last_q;
  assign bus.io_timing1st  = t_first_q;
  assign bus.io_timingMax  = t_max_q;
  assign bus.io_timingMin  = t_min_q;
  assign bus.io_sampleCnt  = sample_cnt_q;
  assign bus.io_toCnt      = to_cnt_q;
endmodule

// File: tb/tb_sync_timing_stat.sv
// Self-checking bench for sync_timing_stat: directed table, corner sequences, random vs model.
module tb_sync_timing_stat;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sync_timing_stat_if bus ();
  sync_timing_stat dut (.io_clk(clk), .io_rst_n(rst_n), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: latency is the distance in clock edges from the start edge.
  longint      m_edge;
  longint      m_start;
  bit          m_tp, m_cp, m_busy, m_valid;
  int unsigned m_q[$];
  int unsigned m_to;
  logic [31:0] m_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_edge();
    bit tr, cr;
    longint lat;
    if (!rst_n) begin
      m_tp = 1'b0; m_cp = 1'b0; m_busy = 1'b0; m_valid = 1'b0;
      m_q.delete(); m_to = 0; m_last = 32'd0;
    end else begin
      tr = bus.io_trigIn && !m_tp;
      cr = bus.io_fbCatch && !m_cp;
      m_tp = bus.io_trigIn;
      m_cp = bus.io_fbCatch;
      m_valid = 1'b0;
      if (bus.io_clear) begin
        m_busy = 1'b0; m_q.delete(); m_to = 0; m_last = 32'd0;
      end else if (!m_busy) begin
        if (tr && !bus.work_End) begin
          m_busy = 1'b1;
          m_start = m_edge;
        end
      end else begin
        lat = m_edge - m_start;
        if (lat > 64'hFFFF_FFFF) lat = 64'hFFFF_FFFF;
        if (cr) begin
          m_q.push_back(int'(lat));
          m_last = lat[31:0];
          m_valid = 1'b1;
          m_busy = 1'b0;
        end else if (bus.io_timeoutCnt != 32'd0 && lat == longint'(bus.io_timeoutCnt)) begin
          m_to++;
          m_busy = 1'b0;
        end
      end
    end
    m_edge++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    logic [31:0] mx, mn, fst;
    logic [15:0] sc, tc;
    mx = 32'd0; mn = 32'd0; fst = 32'd0;
    foreach (m_q[i]) begin
      if (i == 0 || m_q[i] > mx) mx = m_q[i];
      if (i == 0 || m_q[i] < mn) mn = m_q[i];
    end
    if (m_q.size() > 0) fst = m_q[0];
    sc = (m_q.size() > 65535) ? 16'hFFFF : 16'(m_q.size());
    tc = (m_to > 65535) ? 16'hFFFF : 16'(m_to);
    check({tag, ".busy"},  bus.io_busy,       m_busy);
    check({tag, ".valid"}, bus.io_valid,      m_valid);
    check({tag, ".has"},   bus.io_hasSample,  m_q.size() > 0);
    check({tag, ".last"},  bus.io_timingLast, m_last);
    check({tag, ".first"}, bus.io_timing1st,  fst);
    check({tag, ".max"},   bus.io_timingMax,  mx);
    check({tag, ".min"},   bus.io_timingMin,  mn);
    check({tag, ".scnt"},  bus.io_sampleCnt,  sc);
    check({tag, ".tcnt"},  bus.io_toCnt,      tc);
  endtask

  // One measurement: trig edge, optional retrigger, catch edge 'gap' cycles later.
  task automatic run_meas(input int gap, input bit we_pre, input bit we_mid,
                          input bit catch_at_start, input int retrig);
    bus.io_trigIn = 1'b0; bus.io_fbCatch = 1'b0; bus.work_End = 1'b0;
    repeat (3) step();
    bus.work_End = we_pre; bus.io_trigIn = 1'b1; bus.io_fbCatch = catch_at_start;
    step();
    bus.io_trigIn = 1'b0; bus.io_fbCatch = 1'b0; bus.work_End = we_mid;
    for (int k = 1; k < gap; k++) begin
      bus.io_trigIn = (k == retrig);
      step();
    end
    bus.io_trigIn = 1'b0; bus.io_fbCatch = 1'b1;
    step();
  endtask

  typedef struct {
    int          gap;
    logic [31:0] to;
    bit          we;
    bit          e_valid;
    logic [31:0] e_last, e_first, e_min, e_max;
    logic [15:0] e_cnt, e_to;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{300, 32'd0,   1'b0, 1'b1, 32'd300, 32'd300, 32'd300, 32'd300, 16'd1, 16'd0};
    tbl[1] = '{150, 32'd0,   1'b0, 1'b1, 32'd150, 32'd300, 32'd150, 32'd300, 16'd2, 16'd0};
    tbl[2] = '{450, 32'd0,   1'b0, 1'b1, 32'd450, 32'd300, 32'd150, 32'd450, 16'd3, 16'd0};
    tbl[3] = '{260, 32'd200, 1'b0, 1'b0, 32'd450, 32'd300, 32'd150, 32'd450, 16'd3, 16'd1};
    tbl[4] = '{200, 32'd200, 1'b0, 1'b1, 32'd200, 32'd300, 32'd150, 32'd450, 16'd4, 16'd1};
    tbl[5] = '{100, 32'd0,   1'b1, 1'b0, 32'd200, 32'd300, 32'd150, 32'd450, 16'd4, 16'd1};
    tbl[6] = '{1,   32'd0,   1'b0, 1'b1, 32'd1,   32'd300, 32'd1,   32'd450, 16'd5, 16'd1};

    m_edge = 0; m_start = 0;
    bus.io_trigIn = 1'b1; bus.io_fbCatch = 1'b0; bus.io_timeoutCnt = 32'd0;
    bus.io_clear = 1'b0; bus.work_End = 1'b0;
    #2 rst_n = 1'b0;
    repeat (100) step();
    check("reset.busy",  bus.io_busy,       1'b0);
    check("reset.valid", bus.io_valid,      1'b0);
    check("reset.has",   bus.io_hasSample,  1'b0);
    check("reset.stats", {bus.io_timingLast, bus.io_timing1st}, 64'd0);
    check("reset.mm",    {bus.io_timingMax, bus.io_timingMin},  64'd0);
    check("reset.cnts",  {bus.io_sampleCnt, bus.io_toCnt},      64'd0);
    rst_n = 1'b1;
    step();
    check("release.busy", bus.io_busy, 1'b1);
    bus.io_clear = 1'b1;
    step();
    bus.io_clear = 1'b0;
    check("release.clear_busy", bus.io_busy, 1'b0);

    foreach (tbl[i]) begin
      bus.io_timeoutCnt = tbl[i].to;
      run_meas(tbl[i].gap, tbl[i].we, 1'b0, 1'b0, 0);
      check($sformatf("tbl%0d.valid", i), bus.io_valid,      tbl[i].e_valid);
      check($sformatf("tbl%0d.busy", i),  bus.io_busy,       1'b0);
      check($sformatf("tbl%0d.last", i),  bus.io_timingLast, tbl[i].e_last);
      check($sformatf("tbl%0d.first", i), bus.io_timing1st,  tbl[i].e_first);
      check($sformatf("tbl%0d.min", i),   bus.io_timingMin,  tbl[i].e_min);
      check($sformatf("tbl%0d.max", i),   bus.io_timingMax,  tbl[i].e_max);
      check($sformatf("tbl%0d.scnt", i),  bus.io_sampleCnt,  tbl[i].e_cnt);
      check($sformatf("tbl%0d.tcnt", i),  bus.io_toCnt,      tbl[i].e_to);
    end
    bus.io_timeoutCnt = 32'd0;

    // Timeout boundary: busy still high after 199 cycles, low after 200.
    bus.io_timeoutCnt = 32'd200; bus.io_fbCatch = 1'b0; bus.io_trigIn = 1'b0;
    repeat (3) step();
    bus.io_trigIn = 1'b1;
    step();
    bus.io_trigIn = 1'b0;
    repeat (199) step();
    check("to.busy199", bus.io_busy, 1'b1);
    step();
    check("to.busy200", bus.io_busy,  1'b0);
    check("to.valid",   bus.io_valid, 1'b0);
    check("to.tcnt",    bus.io_toCnt, 16'd2);
    check("to.scnt",    bus.io_sampleCnt, 16'd5);
    bus.io_timeoutCnt = 32'd0;

    run_meas(120, 1'b0, 1'b1, 1'b0, 0);
    check("freeze_mid.valid", bus.io_valid,      1'b1);
    check("freeze_mid.last",  bus.io_timingLast, 32'd120);
    check("freeze_mid.scnt",  bus.io_sampleCnt,  16'd6);

    bus.io_trigIn = 1'b0; bus.io_fbCatch = 1'b0; bus.work_End = 1'b0;
    repeat (3) step();
    bus.io_trigIn = 1'b1;
    step();
    bus.io_trigIn = 1'b0;
    repeat (50) step();
    bus.io_clear = 1'b1;
    step();
    bus.io_clear = 1'b0;
    check("clear.busy",  bus.io_busy, 1'b0);
    check("clear.has",   bus.io_hasSample, 1'b0);
    check("clear.stats", {bus.io_timingLast, bus.io_timing1st}, 64'd0);
    check("clear.mm",    {bus.io_timingMax, bus.io_timingMin},  64'd0);
    check("clear.cnts",  {bus.io_sampleCnt, bus.io_toCnt},      64'd0);
    bus.io_fbCatch = 1'b1;
    step();
    check("clear.late_valid", bus.io_valid,      1'b0);
    check("clear.late_has",   bus.io_hasSample,  1'b0);

    run_meas(50, 1'b0, 1'b0, 1'b1, 0);
    check("same_cycle.valid", bus.io_valid,      1'b1);
    check("same_cycle.last",  bus.io_timingLast, 32'd50);
    check("same_cycle.first", bus.io_timing1st,  32'd50);
    check("same_cycle.scnt",  bus.io_sampleCnt,  16'd1);

    run_meas(80, 1'b0, 1'b0, 1'b0, 10);
    check("retrig.last", bus.io_timingLast, 32'd80);
    check("retrig.max",  bus.io_timingMax,  32'd80);
    check("retrig.min",  bus.io_timingMin,  32'd50);
    check("retrig.scnt", bus.io_sampleCnt,  16'd2);

    compare_model("pre_rand");
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0)   bus.io_trigIn  = ~bus.io_trigIn;
      if ($urandom_range(0, 9) == 0)   bus.io_fbCatch = ~bus.io_fbCatch;
      if ($urandom_range(0, 99) == 0)  bus.work_End   = ~bus.work_End;
      bus.io_clear = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0)
        bus.io_timeoutCnt = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(3, 40));
      step();
      compare_model($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sync_timing_stat.md
Name: sync_timing_stat

Overview:
- Downstream consumer of one SyncPort channel.
- Measures trigger-to-fallback latency in io_clk cycles. Start is a rising edge of SyncPort io_delayOut; stop is a rising edge of io_fbCatch.
- Keeps first, last, max and min latency, a sample count and a timeout count for the host register bank.
- Freezes on work_End.

Parameters:
_RAM_WIDTH_TIMING, 32, width of the latency counter and all timing outputs
_CNT_WIDTH, 16, width of the sample and timeout counters

Ports:
io_clk  input  1  system clock, 10 MHz nominal
io_rst_n  input  1  asynchronous active-low reset
io_trigIn  input  1  start source, tied to SyncPort io_delayOut, level signal
io_fbCatch  input  1  stop source, tied to SyncPort io_fbCatch, level signal
io_timeoutCnt  input  _RAM_WIDTH_TIMING  timeout limit in cycles; 0 disables the timeout
io_clear  input  1  synchronous clear of statistics and counters
work_End  input  1  freeze request, level
io_busy  output  1  high while a measurement is in progress
io_valid  output  1  one-cycle strobe when a new latency is stored
io_hasSample  output  1  high once at least one latency has been stored since reset or clear
io_timingLast  output  _RAM_WIDTH_TIMING  latest latency
io_timing1st  output  _RAM_WIDTH_TIMING  first latency since reset or clear
io_timingMax  output  _RAM_WIDTH_TIMING  maximum latency
io_timingMin  output  _RAM_WIDTH_TIMING  minimum latency
io_sampleCnt  output  _CNT_WIDTH  number of stored latencies, saturating
io_toCnt  output  _CNT_WIDTH  number of timeouts, saturating

Behaviour:
- Reset:
  - On io_rst_n low, every register and output goes to 0 asynchronously, including io_timingMin. State goes to IDLE.
  - Release is used synchronously: the first active edge is the one after io_rst_n goes high.
- Edge detection:
  - io_trigIn and io_fbCatch are each registered once.
  - trig_rise = io_trigIn & ~trig_d; catch_rise = io_fbCatch & ~catch_d.
  - Both edge detect registers reset to 0, so an input that is high at reset release produces an edge on the first clock.
- States: IDLE and MEAS.
- IDLE:
  - catch_rise is ignored.
  - On trig_rise with work_End low: go to MEAS, load lat_cnt = 1, set io_busy.
  - trig_rise while work_End is high is dropped.
- MEAS, on each clock, in this priority order:
  1. catch_rise: latency = lat_cnt, meaning a catch edge N cycles after the trig edge cycle gives N. Store statistics, pulse io_valid for one cycle, go to IDLE.
  2. io_timeoutCnt != 0 and lat_cnt == io_timeoutCnt: increment io_toCnt (saturating), go to IDLE. No statistics update, no io_valid.
  3. Otherwise lat_cnt increments, saturating at all-ones.
  - trig_rise during MEAS is ignored; there is no retrigger.
  - work_End rising during MEAS does not abort the measurement in flight.
- Statistics update on a stored latency L:
  - io_timingLast = L.
  - If io_hasSample is 0: io_timing1st = io_timingMin = io_timingMax = L, and io_hasSample goes to 1.
  - Otherwise: io_timingMax = max(io_timingMax, L) and io_timingMin = min(io_timingMin, L), unsigned compare. io_timing1st is unchanged.
  - io_sampleCnt increments and holds at all-ones.
  - All outputs change in the same cycle as io_valid.
- Saturation: a saturated lat_cnt with the timeout disabled still ends on catch_rise and stores all-ones.
- io_clear (synchronous, highest priority):
  - Zeroes the statistics, both counters and io_hasSample.
  - Forces IDLE, drops io_busy, suppresses io_valid in that cycle.
  - Edge detect registers keep sampling, so an edge coincident with io_clear is lost.
- Simultaneous trig_rise and catch_rise in IDLE: the measurement starts and the catch is ignored.
- Timeout with catch_rise in the same cycle: the catch wins and the latency is stored.

Test Plan:
- Reset: hold io_rst_n low for 100 cycles with io_trigIn=1 -> all outputs 0. One cycle after release, io_busy=1 (reset-release edge).
- Single sample: trig edge, catch edge 300 cycles later -> io_valid pulse; io_timingLast = io_timing1st = io_timingMax = io_timingMin = 300; io_sampleCnt = 1; io_hasSample = 1.
- Min/max: latencies 300, 150, 450 in sequence -> 1st=300, min=150, max=450, last=450, io_sampleCnt=3.
- Timeout: io_timeoutCnt=200, no catch -> io_toCnt=1 and io_busy drops 200 cycles after the trig edge, no io_valid. Repeat with catch at 200 -> sample 200 stored, io_toCnt unchanged.
- Freeze and clear:
  - work_End=1 before a trig edge -> no measurement.
  - work_End=1 during MEAS with catch after 120 cycles -> 120 stored.
  - io_clear mid-measurement -> all statistics 0, io_busy=0, the later catch is ignored.
- Edge cases:
  - trig and catch rising in the same IDLE cycle -> MEAS entered; a catch 50 cycles later stores 50.
  - Second trig edge during MEAS -> latency still measured from the first edge.
